// File: rtl/vga_scan_ctrl.sv
// VGA scan timing generator with a one-stage registered, masked RGB/sync output.
// The counters produce the scan coordinates for the renderers. Their colour comes
// back combinationally and is registered together with sync and blank, so every
// DAC pin carries the same one-cycle latency.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x_cnt,
  output logic [9:0] y_cnt,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       active0;
  logic       hs0;
  logic       vs0;
  logic       tick0;

  assign x_cnt      = h_cnt;
  assign y_cnt      = v_cnt;
  assign vga_sync_n = 1'b0;

  // Scan counters: the horizontal counter runs every cycle and the vertical counter steps on the line wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (h_wrap) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Stage-0 decodes from the current scan position.
  always_comb begin
    h_wrap  = (h_cnt == H_LAST);
    active0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs0     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs0     = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    tick0   = (h_cnt == 10'd0) && (v_cnt == V_VIS);
  end

  // Output register: colour is forced to black outside the active region so renderer garbage never reaches the DAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      vga_r       <= active0 ? r_in : 8'd0;
      vga_g       <= active0 ? g_in : 8'd0;
      vga_b       <= active0 ? b_in : 8'd0;
      vga_hs      <= hs0;
      vga_vs      <= vs0;
      vga_blank_n <= active0;
      frame_tick  <= tick0;
    end
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Pixel-clock timing generator and output register stage for the 640x480@60 VGA path on the DE2-115 (25 MHz pixel clock).
- Drives the x_cnt/y_cnt scan coordinates that feed the card and number sprite renderers.
- Takes back their combined r/g/b, then registers and masks it, aligned with sync and blank, for the ADV7123 DAC pins.
- Issues a per-frame tick so game logic can update sprite pins and colours during vertical blanking.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  synchronous reset, active-high
- x_cnt  out  10  current horizontal scan position, 0..H_TOTAL-1
- y_cnt  out  10  current vertical scan position, 0..V_TOTAL-1
- r_in  in  8  red from the sprite/compositor path, combinational from x_cnt/y_cnt
- g_in  in  8  green, same timing as r_in
- b_in  in  8  blue, same timing as r_in
- vga_r  out  8  registered red to DAC
- vga_g  out  8  registered green to DAC
- vga_b  out  8  registered blue to DAC
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_blank_n  out  1  low outside the active region
- vga_sync_n  out  1  constant 0 (no sync-on-green)
- frame_tick  out  1  one-cycle pulse at the start of vertical blanking

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). All comparisons are 10-bit unsigned.
- Horizontal counter: h_cnt increments every cycle. At H_TOTAL-1 it wraps to 0.
- Vertical counter: v_cnt increments only on the cycle h_cnt wraps. At V_TOTAL-1, coincident with the h wrap, it wraps to 0.
- Scan outputs: x_cnt = h_cnt and y_cnt = v_cnt, both registered state with no extra delay.
- Region order on each axis: active, then front porch, then sync, then back porch.
- Stage-0 decodes:
  - active0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs0 low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751
  - vs0 low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491
- Output stage, one register, latency 1 from x_cnt/y_cnt:
  - vga_r/g/b <= active0 ? r_in/g_in/b_in : 0
  - vga_hs <= hs0; vga_vs <= vs0; vga_blank_n <= active0
  - Result: pixel (x,y) appears on the DAC pins the cycle after x_cnt=x, y_cnt=y, with sync and blank aligned to it.
- frame_tick: registered and high for exactly one cycle, the cycle after h_cnt=0 and v_cnt=V_ACTIVE. That gives 45 lines of blanking before the next active pixel.
- Reset values:
  - h_cnt=0, v_cnt=0
  - vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_tick=0
  - First post-reset cycle presents x_cnt=0, y_cnt=0.
- Reset mid-frame: counters return to 0 on the next edge regardless of position; the output stage clears the same cycle with no partial pulse. frame_tick is not asserted by reset itself.
- Out-of-active inputs: r_in/g_in/b_in are don't-care outside the active region. Renderers may output anything there; the DAC must still see 0.

Test Plan:
- Reset then run: hold rst 3 cycles and release. Required: x_cnt counts 0,1,2..., vga_blank_n=0 on the first post-reset edge, and vga_blank_n=1 with the rgb value for (0,0) on the next.
- Line timing: observe vga_hs. Required: low for exactly 96 cycles, falling one cycle after x_cnt=656, period 800 cycles; y_cnt increments when x_cnt goes 799->0.
- Frame timing: observe vga_vs and frame_tick. Required: vga_vs low for 2 lines (1600 cycles) starting one cycle after x_cnt=0, y_cnt=490; frame_tick pulses once per 420000 cycles, one cycle after x_cnt=0, y_cnt=480; y_cnt wraps 524->0.
- Masking and latency: drive r_in=0xFF, g_in=0xC0, b_in=0x00 constantly. Required: vga_* equal those values exactly while vga_blank_n=1, and all 0 at cycles following x_cnt=640..799 or y_cnt>=480.
- Reset mid-frame: assert rst for one cycle at x_cnt=700, y_cnt=491, inside both syncs. Required: next cycle vga_hs=1, vga_vs=1, rgb=0, blank_n=0; the following cycle x_cnt=1, y_cnt=0.
- Coordinate pipe check: drive r_in={x_cnt[7:0]} from the bench. Required: vga_r in visible line y=10 reads 0,1,...,255,0,... aligned, with the first visible pixel equal to 0.
